// File: rtl/source_arbiter_if.sv
// source_arbiter_if: input-source words, mode select, console latch and frame word for source_arbiter.
interface source_arbiter_if;
  logic [7:0] kb_word;
  logic       kb_valid;
  logic [7:0] ir_word;
  logic       ir_valid;
  logic [7:0] btn_word;
  logic [1:0] dip;
  logic       latch_in;
  logic [7:0] word_out;
  logic [1:0] active_src;
  modport master (
    output kb_word, kb_valid, ir_word, ir_valid, btn_word, dip, latch_in,
    input  word_out, active_src
  );
  modport slave (
    input  kb_word, kb_valid, ir_word, ir_valid, btn_word, dip, latch_in,
    output word_out, active_src
  );
endinterface

// File: rtl/source_arbiter.sv
// source_arbiter: picks one of KB/IR/BTN as owner with idle timeout and presents its word frame-stably on latch edges.
module source_arbiter #(
  parameter int HOLD_TICKS = 2000,
  parameter int CNT_W      = 12
) (
  input  logic            clk,
  input  logic            reset_n,
  source_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    OWN_KB  = 2'b01,
    OWN_IR  = 2'b10,
    OWN_BTN = 2'b11
  } state_e;
  localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_TICKS);
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       kb_hold_q;
  logic [7:0]       ir_hold_q;
  logic [7:0]       btn_s1_q;
  logic [7:0]       btn_s2_q;
  logic [7:0]       word_q;
  logic             lat_s1_q;
  logic             lat_s2_q;
  logic             lat_d_q;
  logic             btn_act;
  logic             owner_act;
  logic             lat_rise;
  logic [7:0]       word_d;
  always_comb begin
    btn_act   = |btn_s2_q;
    owner_act = state_q == OWN_KB  ? bus.kb_valid :
                state_q == OWN_IR  ? bus.ir_valid :
                state_q == OWN_BTN ? btn_act      : 1'b0;
    lat_rise  = lat_s2_q & ~lat_d_q;
    word_d    = state_q == OWN_KB  ? kb_hold_q :
                state_q == OWN_IR  ? ir_hold_q :
                state_q == OWN_BTN ? btn_s2_q  : 8'h00;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      kb_hold_q <= 8'h00;
      ir_hold_q <= 8'h00;
      btn_s1_q  <= 8'h00;
      btn_s2_q  <= 8'h00;
      word_q    <= 8'h00;
      lat_s1_q  <= 1'b0;
      lat_s2_q  <= 1'b0;
      lat_d_q   <= 1'b0;
    end else begin
      btn_s1_q <= bus.btn_word;
      btn_s2_q <= btn_s1_q;
      lat_s1_q <= bus.latch_in;
      lat_s2_q <= lat_s1_q;
      lat_d_q  <= lat_s2_q;
      if (bus.kb_valid) kb_hold_q <= bus.kb_word;
      if (bus.ir_valid) ir_hold_q <= bus.ir_word;
      // word_d reflects the owner before this edge, so a simultaneous grant or release cannot leak in
      if (lat_rise) word_q <= word_d;
      if (bus.dip != 2'b00) begin
        state_q <= state_e'(bus.dip);
        cnt_q   <= HOLD;
      end else if (state_q == IDLE) begin
        if (btn_act || bus.kb_valid || bus.ir_valid) begin
          state_q <= btn_act ? OWN_BTN : bus.kb_valid ? OWN_KB : OWN_IR;
          cnt_q   <= HOLD;
        end
      end else if (owner_act) begin
        cnt_q <= HOLD;
      end else if (cnt_q == '0) begin
        state_q <= IDLE;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end
  assign bus.word_out   = word_q;
  assign bus.active_src = state_q;
endmodule

// File: doc/source_arbiter.md
SOURCE_ARBITER -- requirements
Module: source_arbiter

Interface
REQ-001 Parameter HOLD_TICKS, default 2000, SHALL set the owner idle-timeout in clk cycles (200 ms at 10 kHz).
REQ-002 Parameter CNT_W, default 12, SHALL set the hold-counter width; HOLD_TICKS SHALL be < 2^CNT_W.
REQ-003 clk  input  1  SHALL be the single block clock; all logic on its rising edge.
REQ-004 reset_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 kb_word  input  8  SHALL carry the decoded keyboard button word, qualified by kb_valid.
REQ-006 kb_valid  input  1  SHALL be a one-cycle pulse marking a new kb_word.
REQ-007 ir_word  input  8  SHALL carry the decoded IR button word, qualified by ir_valid.
REQ-008 ir_valid  input  1  SHALL be a one-cycle pulse marking a new ir_word.
REQ-009 btn_word  input  8  SHALL carry the active-high button-board word, level, asynchronous to clk.
REQ-010 dip  input  2  SHALL select mode: 00 auto, 01 force KB, 10 force IR, 11 force BTN.
REQ-011 latch_in  input  1  SHALL carry the console latch, asynchronous to clk.
REQ-012 word_out  output  8  SHALL carry the frame-stable word for the SNES encoder.
REQ-013 active_src  output  2  SHALL report the owner: 00 none, 01 KB, 10 IR, 11 BTN.

Function
REQ-014 btn_word and latch_in SHALL each pass through a 2-flop synchronizer before use.
REQ-015 kb_word/ir_word SHALL be captured into per-source hold registers on the cycle their valid is high; the BTN hold register SHALL be the synchronized btn_word.
REQ-016 Activity SHALL be: KB = kb_valid; IR = ir_valid; BTN = synchronized btn_word nonzero.
REQ-017 FSM states SHALL be IDLE, OWN_KB, OWN_IR, OWN_BTN; active_src SHALL be the registered state encoding (00/01/10/11).
REQ-018 Auto mode, IDLE: the first active source SHALL be granted on the next edge; simultaneous activity priority BTN > KB > IR.
REQ-019 Auto mode, OWN_x: activity from non-owners SHALL be ignored; owner activity SHALL reload the hold counter to HOLD_TICKS.
REQ-020 Auto mode, OWN_x without owner activity: counter SHALL decrement by 1 per cycle; on reaching 0 the FSM SHALL return to IDLE next edge.
REQ-021 Owner activity in the cycle the counter is 0 SHALL win: owner retained, counter reloaded.
REQ-022 Grant SHALL load the counter to HOLD_TICKS in the same edge as the state change.
REQ-023 dip != 00 SHALL force the matching OWN_x state on the next edge regardless of activity, with the counter held at HOLD_TICKS (no timeout).
REQ-024 dip changing from nonzero to 00 SHALL keep the current owner and resume timeout counting from HOLD_TICKS.
REQ-025 A rising edge of synchronized latch SHALL be detected with one further register; word_out SHALL update on the following edge (3 clk edges after latch_in is first sampled high).
REQ-026 word_out SHALL take the owner's hold register, or 8'h00 in IDLE, using the state value registered before the update edge.
REQ-027 word_out SHALL be stable between latch edges; ownership changes SHALL not alter word_out until the next latch edge.
REQ-028 A latch edge and ownership change in the same cycle SHALL use the pre-change owner.
REQ-029 latch_in held high SHALL produce exactly one update.

Reset
REQ-030 reset_n low at a clk edge SHALL force state IDLE, word_out 8'h00, active_src 00, counter 0, all hold, sync and edge registers 0.
REQ-031 Reset asserted mid-ownership or mid-latch-sync SHALL discard pending grants and updates; the first post-reset latch edge SHALL follow REQ-025.

Verification
REQ-032 Auto, kb_valid pulse kb_word=8'h12, then latch pulse -> active_src 01 next edge; word_out 8'h12 3 edges after latch.
REQ-033 Owner KB; ir_valid with 8'h34 during hold; latch -> word_out stays KB word, active_src 01; after HOLD_TICKS+1 idle cycles active_src 00; next latch -> 8'h00.
REQ-034 IDLE; kb_valid and synchronized btn_word=8'h80 in same cycle -> active_src 11; latch -> word_out 8'h80.
REQ-035 dip=10, no IR activity for 3*HOLD_TICKS -> active_src 10 throughout; ir_valid 8'h56 plus latch -> word_out 8'h56.
REQ-036 Owner KB, kb_valid in cycle counter=0 -> active_src remains 01, counter reloads to HOLD_TICKS.
REQ-037 reset_n low one edge during OWN_BTN with latch edge in flight -> word_out 8'h00, active_src 00, no update from the in-flight latch.
